// File: rtl/stopwatch_ctrl_if.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl_if
// Groups the control-side signals of the stopwatch sequencing controller.
//   master : drives the debounced buttons, ExtTick, ClkSel, Speed and the
//            counter flags; observes the counter commands and the LEDs.
//   slave  : the controller itself.
// Signals:
//   ClearBtn/StopBtn/UpBtn/DownBtn  debounced button levels
//   ExtTick                         debounced external clock level
//   ClkSel                          0 = internal prescaler, 1 = ExtTick
//   Speed[4:0]                      internal tick period = (32-Speed) base pulses
//   AtZero/AtMax                    counter flags (0000 / 9999)
//   Step/Dir/Clear                  counter commands
//   ModeOutput[2:0]                 one-hot mode LEDs {PAUSED, RUN_DOWN, RUN_UP}
//   TickLed                         toggles on every tick
// -----------------------------------------------------------------------------
interface stopwatch_ctrl_if;
  logic       ClearBtn;
  logic       StopBtn;
  logic       UpBtn;
  logic       DownBtn;
  logic       ExtTick;
  logic       ClkSel;
  logic [4:0] Speed;
  logic       AtZero;
  logic       AtMax;
  logic       Step;
  logic       Dir;
  logic       Clear;
  logic [2:0] ModeOutput;
  logic       TickLed;

  modport master (
    output ClearBtn, StopBtn, UpBtn, DownBtn, ExtTick, ClkSel, Speed, AtZero, AtMax,
    input  Step, Dir, Clear, ModeOutput, TickLed
  );

  modport slave (
    input  ClearBtn, StopBtn, UpBtn, DownBtn, ExtTick, ClkSel, Speed, AtZero, AtMax,
    output Step, Dir, Clear, ModeOutput, TickLed
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
// Sequencing controller for the 4-digit stopwatch. Turns debounced button
// edges, the speed switches and the tick source select into Step/Dir/Clear
// commands for the BCD counter, and drives the mode and tick LEDs.
// Ports:
//   Clk     system clock (rising edge)
//   nReset  asynchronous active-low reset
//   sw      stopwatch_ctrl_if.slave (buttons, tick source, flags, commands, LEDs)
// Parameters:
//   BASE_DIV  clock cycles per base pulse (>= 2)
//   PRE_W     prescaler width, 2**PRE_W >= BASE_DIV
// -----------------------------------------------------------------------------
module stopwatch_ctrl #(
  parameter int unsigned BASE_DIV = 50000,
  parameter int unsigned PRE_W    = 16
) (
  input  logic               Clk,
  input  logic               nReset,
  stopwatch_ctrl_if.slave    sw
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN_UP   = 2'd1,
    ST_RUN_DOWN = 2'd2,
    ST_PAUSED   = 2'd3
  } state_t;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(BASE_DIV - 32'd1);

  // Mode LED encoding: one-hot {PAUSED, RUN_DOWN, RUN_UP}, all-zero when idle.
  function automatic logic [2:0] mode_of(input state_t s);
    logic [2:0] m;
    case (s)
      ST_RUN_UP:   m = 3'b001;
      ST_RUN_DOWN: m = 3'b010;
      ST_PAUSED:   m = 3'b100;
      default:     m = 3'b000;
    endcase
    return m;
  endfunction

  // Edge-detect history
  logic clear_prev_q, stop_prev_q, up_prev_q, down_prev_q, ext_prev_q, clksel_prev_q;

  // Time base
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [4:0]       spd_q, spd_d;
  logic [4:0]       spd_limit_s;
  logic             int_tick_s;

  // Control state and registered outputs
  state_t     state_q, state_d;
  logic       dir_q, dir_d;
  logic       dir_o_q;
  logic       step_q, step_d;
  logic       clear_q, clear_d;
  logic [2:0] mode_q;
  logic       led_q, led_d;

  logic clear_e_s, stop_e_s, up_e_s, down_e_s, ext_e_s, tick_s;

  assign clear_e_s = sw.ClearBtn & ~clear_prev_q;
  assign stop_e_s  = sw.StopBtn  & ~stop_prev_q;
  assign up_e_s    = sw.UpBtn    & ~up_prev_q;
  assign down_e_s  = sw.DownBtn  & ~down_prev_q;
  assign ext_e_s   = sw.ExtTick  & ~ext_prev_q;

  assign tick_s = sw.ClkSel ? ext_e_s : int_tick_s;

  // Prescaler and speed counter next state; both held at zero while the
  // external tick is selected and restarted on any ClkSel change.
  always_comb begin
    pre_d       = pre_q;
    spd_d       = spd_q;
    int_tick_s  = 1'b0;
    spd_limit_s = 5'd31 - sw.Speed;
    if (sw.ClkSel || (sw.ClkSel != clksel_prev_q)) begin
      pre_d = '0;
      spd_d = 5'd0;
    end else if (pre_q == PRE_LAST) begin
      pre_d = '0;
      // ">=" so a count left above a freshly lowered limit wraps on this pulse
      if (spd_q >= spd_limit_s) begin
        spd_d      = 5'd0;
        int_tick_s = 1'b1;
      end else begin
        spd_d = spd_q + 5'd1;
      end
    end else begin
      pre_d = pre_q + PRE_W'(1);
    end
  end

  // Command decode: only the highest-priority edge acts; a tick only steps
  // the counter in a cycle free of command edges.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    step_d  = 1'b0;
    clear_d = 1'b0;
    led_d   = led_q ^ tick_s;
    if (clear_e_s) begin
      clear_d = 1'b1;
      state_d = ST_IDLE;
      dir_d   = 1'b1;
    end else if (stop_e_s) begin
      case (state_q)
        ST_RUN_UP,
        ST_RUN_DOWN: state_d = ST_PAUSED;
        ST_PAUSED:   state_d = dir_q ? ST_RUN_UP : ST_RUN_DOWN;
        ST_IDLE:     state_d = ST_RUN_UP;
        default:     state_d = ST_IDLE;
      endcase
    end else if (up_e_s) begin
      dir_d   = 1'b1;
      state_d = ST_RUN_UP;
    end else if (down_e_s) begin
      dir_d = 1'b0;
      if (sw.AtZero) begin
        state_d = ST_PAUSED;
      end else begin
        state_d = ST_RUN_DOWN;
      end
    end else if (tick_s) begin
      // Terminal flags pause instead of letting the counter wrap
      case (state_q)
        ST_RUN_UP: begin
          if (sw.AtMax) begin
            state_d = ST_PAUSED;
          end else begin
            step_d = 1'b1;
          end
        end
        ST_RUN_DOWN: begin
          if (sw.AtZero) begin
            state_d = ST_PAUSED;
          end else begin
            step_d = 1'b1;
          end
        end
        default: state_d = state_q;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Edge-detect history registers
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      clear_prev_q  <= 1'b0;
      stop_prev_q   <= 1'b0;
      up_prev_q     <= 1'b0;
      down_prev_q   <= 1'b0;
      ext_prev_q    <= 1'b0;
      clksel_prev_q <= 1'b0;
    end else begin
      clear_prev_q  <= sw.ClearBtn;
      stop_prev_q   <= sw.StopBtn;
      up_prev_q     <= sw.UpBtn;
      down_prev_q   <= sw.DownBtn;
      ext_prev_q    <= sw.ExtTick;
      clksel_prev_q <= sw.ClkSel;
    end
  end

  // Time base registers
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      pre_q <= '0;
      spd_q <= 5'd0;
    end else begin
      pre_q <= pre_d;
      spd_q <= spd_d;
    end
  end

  // State, direction and registered outputs. The internal Dir register
  // starts at 1 while the Dir output starts at 0 and follows it one edge later.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= ST_IDLE;
      dir_q   <= 1'b1;
      dir_o_q <= 1'b0;
      step_q  <= 1'b0;
      clear_q <= 1'b0;
      mode_q  <= 3'b000;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      dir_o_q <= dir_d;
      step_q  <= step_d;
      clear_q <= clear_d;
      mode_q  <= mode_of(state_d);
      led_q   <= led_d;
    end
  end

  assign sw.Step       = step_q;
  assign sw.Dir        = dir_o_q;
  assign sw.Clear      = clear_q;
  assign sw.ModeOutput = mode_q;
  assign sw.TickLed    = led_q;

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Sequencing controller for the 4-digit stopwatch counter datapath.
- Turns debounced button levels, the speed switches and the clock-source select into counter commands: Step, Dir, Clear.
- Generates the internal time base and the mode/tick indication LEDs.
- Sits between the debouncer/synchronizer layer and the BCD counter/display datapath; consumes the counter's AtZero/AtMax flags.

Parameters:
- BASE_DIV, 50000, Clk cycles per base pulse (prescaler modulus, >=2).
- PRE_W, 16, prescaler counter width; must satisfy 2^PRE_W >= BASE_DIV.

Ports:
- Clk  in  1  system clock; all logic is rising-edge.
- nReset  in  1  asynchronous, active-low reset.
- ClearBtn  in  1  debounced level; rising edge = clear.
- StopBtn  in  1  debounced level; rising edge = start/pause toggle.
- UpBtn  in  1  debounced level; rising edge = run counting up.
- DownBtn  in  1  debounced level; rising edge = run counting down.
- ExtTick  in  1  debounced external clock level; rising edge = one tick when ClkSel=1.
- ClkSel  in  1  synchronized; 0 = internal prescaler, 1 = ExtTick.
- Speed  in  5  synchronized; internal tick period = (32-Speed) base pulses.
- AtZero  in  1  counter reads 0000.
- AtMax  in  1  counter reads 9999.
- Step  out  1  one-cycle pulse: counter advances one in direction Dir.
- Dir  out  1  1 = up, 0 = down; valid whenever Step=1.
- Clear  out  1  one-cycle pulse: counter loads 0000.
- ModeOutput  out  3  one-hot: [0] RUN_UP, [1] RUN_DOWN, [2] PAUSED; 000 = IDLE.
- TickLed  out  1  toggles on every tick, whether or not Step is issued.

Behaviour:
- Async reset (nReset=0): state=IDLE, all outputs 0, prescaler and speed counter 0, all edge-detect registers 0. Outputs are registered.
- Edge detect: one previous-value register per button and per ExtTick. An edge is seen in the cycle the level is first sampled 1. The edge-detect registers clear at reset, so a button already held at reset release produces one edge on the first sampled cycle.
- Internal time base:
  - Prescaler counts 0..BASE_DIV-1 and emits a base pulse at wrap.
  - Speed counter counts base pulses 0..(31-Speed) and emits a tick at wrap.
  - If Speed changes mid-period and the speed count exceeds the new limit, the speed counter wraps on the next base pulse.
- Tick source:
  - ClkSel=0: tick = internal tick.
  - ClkSel=1: tick = ExtTick rising edge; the prescaler and speed counter are held at 0.
  - Any ClkSel change resets the prescaler and speed counter to 0.
- States: IDLE, RUN_UP, RUN_DOWN, PAUSED. Dir is a register, initialised to 1.
- Command priority when several edges land in one cycle: Clear > Stop > Up > Down. Only the highest-priority edge acts.
- Clear edge: Clear=1 next cycle; state -> IDLE; Dir -> 1. Legal in any state.
- Stop edge:
  - RUN_UP or RUN_DOWN -> PAUSED.
  - PAUSED -> RUN_UP if Dir=1, else RUN_DOWN.
  - IDLE -> RUN_UP.
- Up edge: Dir -> 1, state -> RUN_UP, from any state.
- Down edge: Dir -> 0, state -> RUN_DOWN. Exception: if AtZero=1, Dir -> 0 and state -> PAUSED.
- Step generation:
  - When tick=1, no command edge in the same cycle, and state is RUN_UP with AtMax=0 (or RUN_DOWN with AtZero=0): Step=1 in the next cycle, with Dir held stable.
  - A tick coinciding with any command edge yields no Step.
- Terminal conditions:
  - Tick in RUN_UP with AtMax=1: no Step; state -> PAUSED.
  - Tick in RUN_DOWN with AtZero=1: no Step; state -> PAUSED.
  - Wrap-around never happens.
- Latency: 1 cycle from the sampled edge or tick to Step/Clear/ModeOutput. Step and Clear are never both 1.
- TickLed toggles the cycle after each tick, in every state, including when the tick is suppressed.
- Reset mid-operation: immediate return to reset values; any pending pulse is dropped.

Test Plan:
- Setup: BASE_DIV=4, Speed=31, ClkSel=0, AtZero=0, AtMax=0. Release reset, then UpBtn edge -> ModeOutput=001. Step pulses every 4 cycles with Dir=1; TickLed toggles every 4 cycles.
- Speed=28 -> Step period 16 cycles. Change Speed to 31 mid-period -> Step period returns to 4 cycles within one base pulse.
- In RUN_UP, StopBtn edge -> ModeOutput=100 and no further Step. A second StopBtn edge -> ModeOutput=001 and Step resumes.
- DownBtn edge with AtZero=0 -> 010 and Step with Dir=0. Then set AtZero=1 -> on the next tick no Step and ModeOutput=100. DownBtn edge while AtZero=1 -> 100.
- ClkSel=1: 3 ExtTick pulses -> exactly 3 Step pulses, each 1 cycle after its ExtTick edge. The prescaler stays at 0 throughout.
- ClearBtn and UpBtn edges in the same cycle, coinciding with a tick -> Clear=1 for one cycle, ModeOutput=000, no Step. nReset=0 asserted mid-RUN_UP -> all outputs 0 asynchronously.
